// File: rtl/sdram_frame_tribuf_ctrl_if.sv
// sdram_frame_tribuf_ctrl_if: frame-done inputs and SDRAM FIFO
// address-window outputs of the triple-buffer frame scheduler.
interface sdram_frame_tribuf_ctrl_if;
  logic        sdram_init_done;
  logic        frame_write_done;
  logic        frame_read_done;
  logic        wr_load;
  logic [21:0] wr_addr;
  logic [21:0] wr_max_addr;
  logic        rd_load;
  logic [21:0] rd_addr;
  logic [21:0] rd_max_addr;
  logic        data_valid;
  logic [1:0]  wr_buf_sel;
  logic [1:0]  rd_buf_sel;
  logic [7:0]  frame_drop_cnt;

  modport master (
    input  sdram_init_done,
    input  frame_write_done,
    input  frame_read_done,
    output wr_load,
    output wr_addr,
    output wr_max_addr,
    output rd_load,
    output rd_addr,
    output rd_max_addr,
    output data_valid,
    output wr_buf_sel,
    output rd_buf_sel,
    output frame_drop_cnt
  );

  modport slave (
    output sdram_init_done,
    output frame_write_done,
    output frame_read_done,
    input  wr_load,
    input  wr_addr,
    input  wr_max_addr,
    input  rd_load,
    input  rd_addr,
    input  rd_max_addr,
    input  data_valid,
    input  wr_buf_sel,
    input  rd_buf_sel,
    input  frame_drop_cnt
  );
endinterface

// File: rtl/sdram_frame_tribuf_ctrl.sv
// sdram_frame_tribuf_ctrl: triple-buffer scheduler keeping the camera
// writer and display reader on different SDRAM frame banks.
module sdram_frame_tribuf_ctrl #(
  parameter int FRAME_WORDS = 307200
) (
  input logic clk_ref,
  input logic rst_n,
  sdram_frame_tribuf_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [21:0] FW = 22'(FRAME_WORDS);
  localparam logic [21:0] B1 = 22'h100000;

  state_t state, state_nxt;

  logic [1:0]  wr_sel, rd_sel, rdy_sel;
  logic        rdy_valid, data_valid;
  logic        wd_d, rd_d;
  logic [7:0]  drop_cnt;
  logic        wr_load, rd_load;
  logic [21:0] wr_addr, wr_max, rd_addr, rd_max;

  logic [1:0] wr_sel_n, rd_sel_n, rdy_sel_n;
  logic       rdy_valid_n, data_valid_n;
  logic       wr_load_n, rd_load_n, drop_inc;
  logic       we, re, swap;
  logic [1:0] free_sel;

  assign we = bus.frame_write_done & ~wd_d;
  assign re = bus.frame_read_done & ~rd_d;
  assign free_sel = 2'd3 - wr_sel - rd_sel;
  // before display starts, any completed frame goes straight to the reader
  assign swap = data_valid ? re : (rdy_valid | we);

  always_ff @(posedge clk_ref) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:  if (bus.sdram_init_done) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    wr_sel_n     = wr_sel;
    rd_sel_n     = rd_sel;
    rdy_sel_n    = rdy_sel;
    rdy_valid_n  = rdy_valid;
    data_valid_n = data_valid;
    wr_load_n    = 1'b0;
    rd_load_n    = 1'b0;
    drop_inc     = 1'b0;
    unique case (state)
      S_INIT: begin
        if (bus.sdram_init_done) begin
          wr_sel_n    = 2'd0;
          rd_sel_n    = 2'd1;
          rdy_valid_n = 1'b0;
          wr_load_n   = 1'b1;
          rd_load_n   = 1'b1;
        end
      end
      S_RUN: begin
        if (we) begin
          wr_sel_n  = free_sel;
          wr_load_n = 1'b1;
          drop_inc  = rdy_valid;
        end
        if (swap) begin
          rd_load_n    = 1'b1;
          data_valid_n = 1'b1;
          if (we) begin
            rd_sel_n    = wr_sel;
            rdy_valid_n = 1'b0;
          end else if (rdy_valid) begin
            rd_sel_n    = rdy_sel;
            rdy_valid_n = 1'b0;
          end
        end else if (we) begin
          rdy_sel_n   = wr_sel;
          rdy_valid_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      wr_sel     <= 2'd0;
      rd_sel     <= 2'd1;
      rdy_sel    <= 2'd2;
      rdy_valid  <= 1'b0;
      data_valid <= 1'b0;
      drop_cnt   <= 8'd0;
      wd_d       <= 1'b0;
      rd_d       <= 1'b0;
      wr_load    <= 1'b0;
      rd_load    <= 1'b0;
      wr_addr    <= 22'd0;
      wr_max     <= FW;
      rd_addr    <= B1;
      rd_max     <= B1 + FW;
    end else begin
      wr_sel     <= wr_sel_n;
      rd_sel     <= rd_sel_n;
      rdy_sel    <= rdy_sel_n;
      rdy_valid  <= rdy_valid_n;
      data_valid <= data_valid_n;
      drop_cnt   <= drop_cnt + {7'd0, drop_inc};
      wd_d       <= bus.frame_write_done;
      rd_d       <= bus.frame_read_done;
      wr_load    <= wr_load_n;
      rd_load    <= rd_load_n;
      wr_addr    <= {wr_sel_n, 20'd0};
      wr_max     <= {wr_sel_n, 20'd0} + FW;
      rd_addr    <= {rd_sel_n, 20'd0};
      rd_max     <= {rd_sel_n, 20'd0} + FW;
    end
  end

  assign bus.wr_load        = wr_load;
  assign bus.wr_addr        = wr_addr;
  assign bus.wr_max_addr    = wr_max;
  assign bus.rd_load        = rd_load;
  assign bus.rd_addr        = rd_addr;
  assign bus.rd_max_addr    = rd_max;
  assign bus.data_valid     = data_valid;
  assign bus.wr_buf_sel     = wr_sel;
  assign bus.rd_buf_sel     = rd_sel;
  assign bus.frame_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_sdram_frame_tribuf_ctrl.sv
// tb_sdram_frame_tribuf_ctrl: directed scenarios plus randomized
// done traffic checked against a frame-level buffer model.
module tb_sdram_frame_tribuf_ctrl;
  logic clk_ref = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  sdram_frame_tribuf_ctrl_if bus();

  sdram_frame_tribuf_ctrl #(.FRAME_WORDS(307200)) dut (
    .clk_ref(clk_ref),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk_ref = ~clk_ref;

  // model of the three buffers: which one is written, read, held ready
  int m_st, m_wr, m_rd, m_rdy, m_drop;
  bit m_rv, m_dv, m_wd, m_rdd, m_wl, m_rl;

  task automatic model_edge();
    bit we, re, swap;
    int ow, orr;
    m_wl = 0;
    m_rl = 0;
    if (!rst_n) begin
      m_st = 0; m_wr = 0; m_rd = 1; m_rdy = 2;
      m_rv = 0; m_dv = 0; m_drop = 0; m_wd = 0; m_rdd = 0;
      return;
    end
    we = bus.frame_write_done && !m_wd;
    re = bus.frame_read_done && !m_rdd;
    m_wd = bus.frame_write_done;
    m_rdd = bus.frame_read_done;
    if (m_st == 0) begin
      if (bus.sdram_init_done) begin
        m_st = 1; m_wl = 1; m_rl = 1; m_wr = 0; m_rd = 1; m_rv = 0;
      end
    end else if (m_st == 1) begin
      m_st = 2;
    end else begin
      ow = m_wr;
      orr = m_rd;
      swap = m_dv ? re : (m_rv || we);
      if (we) begin
        if (m_rv) m_drop = (m_drop + 1) % 256;
        m_wr = 3 - ow - orr;
        m_wl = 1;
      end
      if (swap) begin
        m_rl = 1;
        m_dv = 1;
        if (we) begin
          m_rd = ow; m_rv = 0;
        end else if (m_rv) begin
          m_rd = m_rdy; m_rv = 0;
        end
      end else if (we) begin
        m_rdy = ow; m_rv = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_ref);
    #1;
    model_edge();
  endtask

  task automatic pulse(input bit w, input bit r);
    bus.frame_write_done = w;
    bus.frame_read_done = r;
    tick();
    bus.frame_write_done = 0;
    bus.frame_read_done = 0;
    tick();
  endtask

  task automatic test_reset();
    bus.sdram_init_done = 0;
    bus.frame_write_done = 0;
    bus.frame_read_done = 0;
    rst_n = 0;
    tick();
    tick();
    checks++; if (bus.wr_load !== 1'b0) begin failures++; $display("FAIL rst_wr_load got=%0h exp=0", bus.wr_load); end
    checks++; if (bus.rd_load !== 1'b0) begin failures++; $display("FAIL rst_rd_load got=%0h exp=0", bus.rd_load); end
    checks++; if (bus.wr_addr !== 22'h0) begin failures++; $display("FAIL rst_wr_addr got=%0h exp=0", bus.wr_addr); end
    checks++; if (bus.wr_max_addr !== 22'h04B000) begin failures++; $display("FAIL rst_wr_max got=%0h exp=4b000", bus.wr_max_addr); end
    checks++; if (bus.rd_addr !== 22'h100000) begin failures++; $display("FAIL rst_rd_addr got=%0h exp=100000", bus.rd_addr); end
    checks++; if (bus.rd_max_addr !== 22'h14B000) begin failures++; $display("FAIL rst_rd_max got=%0h exp=14b000", bus.rd_max_addr); end
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL rst_dv got=%0h exp=0", bus.data_valid); end
    checks++; if (bus.frame_drop_cnt !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", bus.frame_drop_cnt); end
    checks++; if (bus.wr_buf_sel !== 2'd0 || bus.rd_buf_sel !== 2'd1) begin failures++; $display("FAIL rst_sel got=%0d/%0d exp=0/1", bus.wr_buf_sel, bus.rd_buf_sel); end
    rst_n = 1;
  endtask

  task automatic test_init_gating(input int hold);
    int loads = 0;
    bus.sdram_init_done = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.wr_load || bus.rd_load) loads++;
    end
    checks++; if (loads !== 0) begin failures++; $display("FAIL init_hold_loads got=%0d exp=0", loads); end
    bus.sdram_init_done = 1;
    tick();
    checks++; if (bus.wr_load !== 1'b1 || bus.rd_load !== 1'b1) begin failures++; $display("FAIL init_loads got=%0h/%0h exp=1/1", bus.wr_load, bus.rd_load); end
    checks++; if (bus.wr_addr !== 22'h0 || bus.wr_max_addr !== 22'h04B000) begin failures++; $display("FAIL init_wr_win got=%0h/%0h exp=0/4b000", bus.wr_addr, bus.wr_max_addr); end
    checks++; if (bus.rd_addr !== 22'h100000 || bus.rd_max_addr !== 22'h14B000) begin failures++; $display("FAIL init_rd_win got=%0h/%0h exp=100000/14b000", bus.rd_addr, bus.rd_max_addr); end
    tick();
    checks++; if (bus.wr_load !== 1'b0 || bus.rd_load !== 1'b0) begin failures++; $display("FAIL init_one_pulse got=%0h/%0h exp=0/0", bus.wr_load, bus.rd_load); end
  endtask

  task automatic test_first_frame();
    bus.frame_write_done = 1;
    tick();
    bus.frame_write_done = 0;
    checks++; if (bus.wr_load !== 1'b1 || bus.rd_load !== 1'b1) begin failures++; $display("FAIL ff_loads got=%0h/%0h exp=1/1", bus.wr_load, bus.rd_load); end
    checks++; if (bus.rd_buf_sel !== 2'd0 || bus.rd_addr !== 22'h0) begin failures++; $display("FAIL ff_rd got=%0d/%0h exp=0/0", bus.rd_buf_sel, bus.rd_addr); end
    checks++; if (bus.wr_buf_sel !== 2'd2 || bus.wr_addr !== 22'h200000) begin failures++; $display("FAIL ff_wr got=%0d/%0h exp=2/200000", bus.wr_buf_sel, bus.wr_addr); end
    checks++; if (bus.data_valid !== 1'b1) begin failures++; $display("FAIL ff_dv got=%0h exp=1", bus.data_valid); end
    tick();
    checks++; if (bus.wr_load !== 1'b0 || bus.rd_load !== 1'b0) begin failures++; $display("FAIL ff_pulse_end got=%0h/%0h exp=0/0", bus.wr_load, bus.rd_load); end
  endtask

  task automatic test_repeat_frame();
    int rp = 0;
    int wp = 0;
    bus.frame_read_done = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rd_load) rp++;
      if (bus.wr_load) wp++;
    end
    bus.frame_read_done = 0;
    tick();
    checks++; if (rp !== 1) begin failures++; $display("FAIL rep_rd_pulses got=%0d exp=1", rp); end
    checks++; if (wp !== 0) begin failures++; $display("FAIL rep_wr_pulses got=%0d exp=0", wp); end
    checks++; if (bus.rd_addr !== 22'h0) begin failures++; $display("FAIL rep_rd_addr got=%0h exp=0", bus.rd_addr); end
  endtask

  task automatic test_overrun();
    bus.frame_write_done = 1;
    tick();
    checks++; if (bus.wr_buf_sel !== 2'd1 || bus.wr_load !== 1'b1) begin failures++; $display("FAIL ovr_wr1 got=%0d/%0h exp=1/1", bus.wr_buf_sel, bus.wr_load); end
    bus.frame_write_done = 0;
    tick();
    bus.frame_write_done = 1;
    tick();
    checks++; if (bus.wr_buf_sel !== 2'd2) begin failures++; $display("FAIL ovr_wr2 got=%0d exp=2", bus.wr_buf_sel); end
    bus.frame_write_done = 0;
    tick();
    checks++; if (bus.frame_drop_cnt !== 8'd1 || bus.rd_buf_sel !== 2'd0) begin failures++; $display("FAIL ovr_drop got=%0d/%0d exp=1/0", bus.frame_drop_cnt, bus.rd_buf_sel); end
    bus.frame_read_done = 1;
    tick();
    checks++; if (bus.rd_buf_sel !== 2'd1 || bus.rd_load !== 1'b1) begin failures++; $display("FAIL ovr_rd got=%0d/%0h exp=1/1", bus.rd_buf_sel, bus.rd_load); end
    bus.frame_read_done = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    pulse(1, 0); pulse(1, 0); pulse(0, 1);
    pulse(1, 0); pulse(0, 1);
    pulse(1, 0); pulse(0, 1);
    pulse(1, 0);
    checks++; if (bus.wr_buf_sel !== 2'd2 || bus.rd_buf_sel !== 2'd1 || bus.frame_drop_cnt !== 8'd2) begin
      failures++; $display("FAIL sim_pre got=%0d/%0d/%0d exp=2/1/2", bus.wr_buf_sel, bus.rd_buf_sel, bus.frame_drop_cnt); end
    bus.frame_write_done = 1;
    bus.frame_read_done = 1;
    tick();
    bus.frame_write_done = 0;
    bus.frame_read_done = 0;
    checks++; if (bus.rd_buf_sel !== 2'd2 || bus.wr_buf_sel !== 2'd0) begin failures++; $display("FAIL sim_sel got=%0d/%0d exp=2/0", bus.rd_buf_sel, bus.wr_buf_sel); end
    checks++; if (bus.wr_load !== 1'b1 || bus.rd_load !== 1'b1) begin failures++; $display("FAIL sim_loads got=%0h/%0h exp=1/1", bus.wr_load, bus.rd_load); end
    checks++; if (bus.frame_drop_cnt !== 8'd3) begin failures++; $display("FAIL sim_drop got=%0d exp=3", bus.frame_drop_cnt); end
    tick();
    bus.frame_read_done = 1;
    tick();
    bus.frame_read_done = 0;
    checks++; if (bus.rd_buf_sel !== 2'd2 || bus.rd_load !== 1'b1) begin failures++; $display("FAIL sim_rdy_cleared got=%0d/%0h exp=2/1", bus.rd_buf_sel, bus.rd_load); end
    tick();
  endtask

  task automatic test_reset_midrun();
    bus.frame_write_done = 1;
    tick();
    bus.frame_write_done = 0;
    rst_n = 0;
    bus.sdram_init_done = 0;
    tick();
    rst_n = 1;
    checks++; if (bus.wr_load !== 1'b0 || bus.rd_load !== 1'b0) begin failures++; $display("FAIL mr_loads got=%0h/%0h exp=0/0", bus.wr_load, bus.rd_load); end
    checks++; if (bus.wr_addr !== 22'h0 || bus.rd_addr !== 22'h100000) begin failures++; $display("FAIL mr_addr got=%0h/%0h exp=0/100000", bus.wr_addr, bus.rd_addr); end
    checks++; if (bus.wr_max_addr !== 22'h04B000 || bus.rd_max_addr !== 22'h14B000) begin failures++; $display("FAIL mr_max got=%0h/%0h exp=4b000/14b000", bus.wr_max_addr, bus.rd_max_addr); end
    checks++; if (bus.data_valid !== 1'b0 || bus.frame_drop_cnt !== 8'd0) begin failures++; $display("FAIL mr_dv_drop got=%0h/%0d exp=0/0", bus.data_valid, bus.frame_drop_cnt); end
    test_init_gating(10);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_write_done = ($urandom_range(0, 2) == 0);
      bus.frame_read_done = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (bus.wr_load !== m_wl || bus.rd_load !== m_rl) begin failures++; $display("FAIL rnd_loads cyc=%0d got=%0h/%0h exp=%0h/%0h", i, bus.wr_load, bus.rd_load, m_wl, m_rl); end
      checks++; if (bus.wr_buf_sel !== 2'(m_wr) || bus.rd_buf_sel !== 2'(m_rd)) begin failures++; $display("FAIL rnd_sel cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.wr_buf_sel, bus.rd_buf_sel, m_wr, m_rd); end
      checks++; if (bus.wr_addr !== 22'(m_wr * 1048576) || bus.wr_max_addr !== 22'(m_wr * 1048576 + 307200)) begin failures++; $display("FAIL rnd_wr_win cyc=%0d got=%0h/%0h", i, bus.wr_addr, bus.wr_max_addr); end
      checks++; if (bus.rd_addr !== 22'(m_rd * 1048576) || bus.rd_max_addr !== 22'(m_rd * 1048576 + 307200)) begin failures++; $display("FAIL rnd_rd_win cyc=%0d got=%0h/%0h", i, bus.rd_addr, bus.rd_max_addr); end
      checks++; if (bus.data_valid !== m_dv || bus.frame_drop_cnt !== 8'(m_drop)) begin failures++; $display("FAIL rnd_dv_drop cyc=%0d got=%0h/%0d exp=%0h/%0d", i, bus.data_valid, bus.frame_drop_cnt, m_dv, m_drop); end
      checks++; if (bus.wr_buf_sel === bus.rd_buf_sel) begin failures++; $display("FAIL rnd_same_buf cyc=%0d got=%0d exp=distinct", i, bus.wr_buf_sel); end
    end
    bus.frame_write_done = 0;
    bus.frame_read_done = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_init_gating(100);
    test_first_frame();
    test_repeat_frame();
    test_overrun();
    test_simultaneous();
    test_reset_midrun();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_frame_tribuf_ctrl.md
# sdram_frame_tribuf_ctrl

Triple-buffer frame scheduler for the SDRAM dual-FIFO frame store. It owns the write and read address windows: it drives `wr_load`/`wr_addr`/`wr_max_addr` and `rd_load`/`rd_addr`/`rd_max_addr` on the SDRAM FIFO top, and gates the display `data_valid`. The camera writer and display reader therefore never touch the same frame buffer. It sits between the capture/display timing logic and the SDRAM FIFO top, in the SDRAM reference clock domain.

## Interface
- `FRAME_WORDS`, default 307200: words per frame (640×480×16-bit). Must be ≤ 2^20.
- `clk_ref` in 1: SDRAM reference clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `sdram_init_done` in 1: SDRAM initialisation complete (level).
- `frame_write_done` in 1: writer finished one frame; rising-edge detected.
- `frame_read_done` in 1: reader finished one frame; rising-edge detected.
- `wr_load` out 1: one-cycle pulse; resets the write address to `wr_addr`.
- `wr_addr` out 22: write window base, `{wr_buf_sel, 20'd0}`.
- `wr_max_addr` out 22: `wr_addr + FRAME_WORDS`.
- `rd_load` out 1: one-cycle pulse; resets the read address to `rd_addr`.
- `rd_addr` out 22: read window base, `{rd_buf_sel, 20'd0}`.
- `rd_max_addr` out 22: `rd_addr + FRAME_WORDS`.
- `data_valid` out 1: display read enable; high once the first complete frame exists.
- `wr_buf_sel` out 2: buffer currently being written (0..2).
- `rd_buf_sel` out 2: buffer currently being read (0..2).
- `frame_drop_cnt` out 8: count of completed frames overwritten unread; wraps modulo 256.

## Operation
- There are three buffers, 0/1/2, mapped to SDRAM banks 0/1/2 (address bits [21:20]). Bank 3 is unused.
- Internal state:
  - `wr_sel`, `rd_sel`, `rdy_sel` (2 bits each);
  - `rdy_valid`;
  - done edge-detect registers `wd_d` and `rd_d`.
- Invariants:
  - `wr_sel != rd_sel` at all times.
  - When `rdy_valid` is set, `rdy_sel` differs from both `wr_sel` and `rd_sel`.
- FSM states: S_INIT, S_LOAD, S_RUN.
  - S_INIT: all loads low. Go to S_LOAD when `sdram_init_done` = 1.
  - S_LOAD: assert `wr_load` and `rd_load` for one cycle, with `wr_sel` = 0 and `rd_sel` = 1. Then go to S_RUN.
  - S_RUN: handles the events below. It never leaves S_RUN except via reset. `sdram_init_done` falling is ignored.
- Edge signals: `we = frame_write_done & ~wd_d` and `re = frame_read_done & ~rd_d`. Both are evaluated only in S_RUN.
- Write event (`we`):
  - `rdy_sel <= wr_sel`; `rdy_valid <= 1`.
  - `wr_sel <= 3 - wr_sel - rd_sel`, i.e. the buffer neither written nor read.
  - Pulse `wr_load`.
  - If `rdy_valid` was already 1, increment `frame_drop_cnt`.
- Read event (`re`) while `data_valid` = 1:
  - If `rdy_valid` = 1: `rd_sel <= rdy_sel`, `rdy_valid <= 0`, pulse `rd_load`.
  - Otherwise: keep `rd_sel` and pulse `rd_load` (repeat the same frame).
- Start-up swap: in S_RUN with `data_valid` = 0 and `rdy_valid` = 1, no `re` is needed.
  - `rd_sel <= rdy_sel`, `rdy_valid <= 0`, `data_valid <= 1`, pulse `rd_load`.
- Simultaneous `we` and `re` (or `we` while a start-up swap is due):
  - `rd_sel <= old wr_sel` (the newest frame); `rdy_valid <= 0`.
  - `wr_sel <= 3 - old wr_sel - old rd_sel`.
  - Both loads pulse.
  - `frame_drop_cnt` increments only if the old `rdy_valid` was 1.
- Address arithmetic: 22-bit unsigned. `{sel, 20'd0} + FRAME_WORDS` never overflows because `FRAME_WORDS` ≤ 2^20.

## Timing
- Fully registered outputs. The `*_buf_sel`/`*_addr`/`*_max_addr` outputs equal `{sel, 20'd0}` and `{sel, 20'd0} + FRAME_WORDS` of the current selects.
- A done edge sampled at clock edge n produces the load pulse, new addresses and new selects at edge n+1. Addresses change in the same cycle the load is high.
- Each load pulse is exactly one cycle. Addresses stay stable until the next load.
- A done input held high generates one event only. Back-to-back events on consecutive edges are each honoured.
- `sdram_init_done` sampled high at edge n → S_LOAD at n+1 (loads high) → S_RUN at n+2.
- Reset values (`rst_n` sampled low): state S_INIT.
  - `wr_sel` = 0, `rd_sel` = 1, `rdy_sel` = 2, `rdy_valid` = 0.
  - `wr_load` = `rd_load` = 0, `data_valid` = 0, `frame_drop_cnt` = 0.
  - `wr_addr` = 0, `wr_max_addr` = `FRAME_WORDS`.
  - `rd_addr` = 0x100000, `rd_max_addr` = 0x100000 + `FRAME_WORDS`.
  - `wd_d` = `rd_d` = 0.
- Reset mid-operation aborts everything at the next edge, with no residual pulse.

## Test plan
- Init gating: hold `sdram_init_done` = 0 for 100 cycles, then raise it.
  - Loads stay 0 throughout the hold.
  - Exactly one cycle with `wr_load` = `rd_load` = 1, `wr_addr` = 0x000000, `wr_max_addr` = 0x04B000, `rd_addr` = 0x100000, `rd_max_addr` = 0x14B000.
- First frame: pulse `frame_write_done`.
  - Next cycle: `wr_load` = `rd_load` = 1, `rd_buf_sel` = 0, `rd_addr` = 0, `wr_buf_sel` = 2, `wr_addr` = 0x200000, `data_valid` = 1.
- Repeat frame: `frame_read_done` with no new write.
  - `rd_load` pulses once and `rd_addr` is unchanged.
  - Holding `frame_read_done` high for 10 cycles gives one pulse only.
- Overrun: from wr = 2, rd = 0, issue two `frame_write_done` pulses with no read.
  - `wr_buf_sel` goes 2 → 1 → 2.
  - `frame_drop_cnt` = 1.
  - Then a read event gives `rd_buf_sel` = 1.
- Simultaneous: from wr = 2, rd = 1, rdy = 0 valid, assert `we` and `re` on the same edge.
  - `rd_buf_sel` = 2, `wr_buf_sel` = 0, `rdy_valid` = 0, both loads pulse, `frame_drop_cnt` +1.
- Reset mid-run: drop `rst_n` for one cycle during a load pulse.
  - Next cycle all outputs equal the reset values.
  - Re-init then behaves exactly as in the init-gating scenario.
